// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes
// and the select codes driven onto the datapath muxes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;

    // ALUOp: what the ALU decoder is asked to produce
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU decoder: maps ALUOp/funct3/funct7 to an ALUControl code and flags
// funct3 values the ALU-type instructions do not support.
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_bit5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    logic [2:0] funct_control;

    // The illegal flag ignores alu_op so DECODE can evaluate it before EXEC
    always_comb begin
        funct_control = ALU_ADD;
        illegal       = 1'b0;
        case (funct3)
            3'b000:  funct_control = (op5 && funct7_bit5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_control = ALU_SLT;
            3'b110:  funct_control = ALU_OR;
            3'b111:  funct_control = ALU_AND;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_control;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-FSM controller for the multicycle RISC-V datapath (lw, sw, R, I, beq,
// jal) with optional memory ready handshake, illegal trap and perf counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit MEM_READY_EN    = 1'b0,
    parameter int CNT_W           = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_bit5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             mem_req,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instret_cnt_reg;

    logic       rdy;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       mem_access;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       f3_illegal;
    logic       op_illegal;
    logic       retire;

    assign rdy = MEM_READY_EN ? mem_ready : 1'b1;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7_bit5 (funct7_bit5),
        .alu_control (alu_control),
        .illegal     (f3_illegal)
    );

    always_comb begin
        op_illegal = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_JAL: op_illegal = 1'b0;
            OP_R, OP_I:                   op_illegal = f3_illegal;
            default:                      op_illegal = 1'b1;
        endcase
    end

    // Datapath controls are a pure function of state; only the ready
    // qualification in memory states looks at an input
    always_comb begin
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_access = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_WD;
        case (state_reg)
            FETCH: begin
                mem_access = 1'b1;
                ir_write   = rdy;
                pc_update  = rdy;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                mem_access = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_access = 1'b1;
                mem_write  = rdy;
            end
            EXECR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_WD;
                alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BEQ: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_WD;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   state_next = rdy ? DECODE : FETCH;
            DECODE: begin
                if (op_illegal) begin
                    state_next = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_R:         state_next = EXECR;
                        OP_I:         state_next = EXECI;
                        OP_BEQ:       state_next = BEQ;
                        default:      state_next = JAL;
                    endcase
                end
            end
            MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = rdy ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = rdy ? FETCH : MEMWRITE;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BEQ:      state_next = FETCH;
            JAL:      state_next = ALUWB;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    // jal retires through ALUWB, so it is counted exactly once there
    assign retire = (state_reg == MEMWB) || (state_reg == ALUWB) ||
                    (state_reg == BEQ) || ((state_reg == MEMWRITE) && rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FETCH;
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg != TRAP) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
            if (retire) begin
                instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign PCWrite     = !rst && (pc_update || (branch && zero));
    assign IRWrite     = !rst && ir_write;
    assign MemWrite    = !rst && mem_write;
    assign RegWrite    = !rst && reg_write;
    assign mem_req     = !rst && mem_access;
    assign trap        = !rst && (state_reg == TRAP);
    assign AdrSrc      = adr_src;
    assign ResultSrc   = result_src;
    assign ALUControl  = alu_control;
    assign ALUSrcA     = alu_src_a;
    assign ALUSrcB     = alu_src_b;
    assign ImmSrc      = imm_src_of(op);
    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (ready handshake off/on) driven from
// a table of per-cycle vectors, expected outputs checked through a queue.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_bit5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready_a = 1'b0;
    logic       mem_ready_b = 1'b1;

    always #5 clk = ~clk;

    logic        pcw_a, adr_a, mw_a, irw_a, mreq_a, rw_a, trap_a;
    logic [1:0]  rs_a, sa_a, sb_a, imm_a;
    logic [2:0]  aluc_a;
    logic [31:0] cyc_a, ins_a;
    logic        pcw_b, adr_b, mw_b, irw_b, mreq_b, rw_b, trap_b;
    logic [1:0]  rs_b, sa_b, sb_b, imm_b;
    logic [2:0]  aluc_b;
    logic [31:0] cyc_b, ins_b;

    multicycle_ctrl #(.MEM_READY_EN(1'b0), .CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit5(funct7_bit5),
        .zero(zero), .mem_ready(mem_ready_a),
        .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a),
        .mem_req(mreq_a), .ResultSrc(rs_a), .ALUControl(aluc_a), .ALUSrcA(sa_a),
        .ALUSrcB(sb_a), .ImmSrc(imm_a), .RegWrite(rw_a), .trap(trap_a),
        .cycle_cnt(cyc_a), .instret_cnt(ins_a)
    );

    multicycle_ctrl #(.MEM_READY_EN(1'b1), .CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit5(funct7_bit5),
        .zero(zero), .mem_ready(mem_ready_b),
        .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b),
        .mem_req(mreq_b), .ResultSrc(rs_b), .ALUControl(aluc_b), .ALUSrcA(sa_b),
        .ALUSrcB(sb_b), .ImmSrc(imm_b), .RegWrite(rw_b), .trap(trap_b),
        .cycle_cnt(cyc_b), .instret_cnt(ins_b)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       mreq;
        logic [1:0] rs;
        logic [2:0] aluc;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic       rw;
        logic       trap;
    } outs_t;

    typedef struct {
        logic       is_rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       rdy;
        logic       both;
        outs_t      exp;
        logic       cc;
        int         cyc;
        int         ins;
    } vec_t;

    outs_t got_a, got_b;
    assign got_a = {pcw_a, adr_a, mw_a, irw_a, mreq_a, rs_a, aluc_a, sa_a, sb_a, imm_a, rw_a, trap_a};
    assign got_b = {pcw_b, adr_b, mw_b, irw_b, mreq_b, rs_b, aluc_b, sa_b, sb_b, imm_b, rw_b, trap_b};

    vec_t  vecs[$];
    outs_t sb_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic outs_t mk(input logic pcw, input logic adr, input logic mw,
                                 input logic irw, input logic mreq, input logic [1:0] rs,
                                 input logic [2:0] aluc, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [1:0] imm,
                                 input logic rw, input logic trp);
        return {pcw, adr, mw, irw, mreq, rs, aluc, sa, sb, imm, rw, trp};
    endfunction

    // Expected outputs per state, transcribed from the state table
    function automatic outs_t st_fetch(input logic r, input logic [1:0] imm);
        return mk(r, 0, 0, r, 1, 2'b10, 3'b000, 2'b00, 2'b10, imm, 0, 0);
    endfunction
    function automatic outs_t st_decode(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, imm, 0, 0);
    endfunction
    function automatic outs_t st_execr(input logic [2:0] aluc);
        return mk(0, 0, 0, 0, 0, 2'b00, aluc, 2'b10, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic outs_t st_execi(input logic [2:0] aluc);
        return mk(0, 0, 0, 0, 0, 2'b00, aluc, 2'b10, 2'b01, 2'b00, 0, 0);
    endfunction
    function automatic outs_t st_aluwb(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, imm, 1, 0);
    endfunction
    function automatic outs_t st_beq(input logic z);
        return mk(z, 0, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, 2'b10, 0, 0);
    endfunction
    function automatic outs_t st_jal();
        return mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b11, 0, 0);
    endfunction
    function automatic outs_t st_memadr(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, imm, 0, 0);
    endfunction
    function automatic outs_t st_memread();
        return mk(0, 1, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic outs_t st_memwb();
        return mk(0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
    endfunction
    function automatic outs_t st_memwrite(input logic r);
        return mk(0, 1, r, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0);
    endfunction
    function automatic outs_t st_trap();
        return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 1);
    endfunction

    task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic r, input logic both, input outs_t e,
                       input logic cc = 1'b0, input int cyc = 0, input int ins = 0);
        vec_t v;
        v.is_rst = 1'b0;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = r; v.both = both;
        v.exp = e; v.cc = cc; v.cyc = cyc; v.ins = ins;
        vecs.push_back(v);
    endtask

    task automatic add_rst();
        vec_t v;
        v = '{default: '0};
        v.is_rst = 1'b1;
        vecs.push_back(v);
    endtask

    // Four-cycle R/I ALU instruction, both instances in lockstep
    task automatic add_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [2:0] aluc, input int cyc, input int ins);
        add(o, f3, f7, 0, 1, 1, st_fetch(1, 2'b00), 1, cyc, ins);
        add(o, f3, f7, 0, 1, 1, st_decode(2'b00));
        add(o, f3, f7, 0, 1, 1, (o == 7'd51) ? st_execr(aluc) : st_execi(aluc));
        add(o, f3, f7, 0, 1, 1, st_aluwb(2'b00));
    endtask

    task automatic check_outs(input string name, input int idx, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    // While rst is high the state is FETCH but every enable must stay low
    task automatic do_reset(input int idx);
        rst = 1'b1;
        mem_ready_b = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_enables_a", idx, {27'd0, pcw_a, irw_a, mw_a, rw_a, mreq_a}, 32'd0);
        check_val("rst_enables_b", idx, {27'd0, pcw_b, irw_b, mw_b, rw_b, mreq_b}, 32'd0);
        check_val("rst_trap_a", idx, {31'd0, trap_a}, 32'd0);
        check_val("rst_trap_b", idx, {31'd0, trap_b}, 32'd0);
        check_val("rst_cycle_cnt", idx, cyc_b, 32'd0);
        check_val("rst_instret_cnt", idx, ins_b, 32'd0);
        $display("vec %0d reset", idx);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        outs_t e;
        // addi, sub, addi with funct7_bit5 set, ori, and, slti
        add_rst();
        add_alu(7'd19, 3'b000, 1'b0, 3'b000, 0, 0);
        add_alu(7'd51, 3'b000, 1'b1, 3'b001, 4, 1);
        add_alu(7'd19, 3'b000, 1'b1, 3'b000, 8, 2);
        add_alu(7'd19, 3'b110, 1'b0, 3'b011, 12, 3);
        add_alu(7'd51, 3'b111, 1'b0, 3'b010, 16, 4);
        add_alu(7'd19, 3'b010, 1'b0, 3'b101, 20, 5);
        // beq taken, then not taken
        add(7'd99, 3'b000, 0, 1, 1, 1, st_fetch(1, 2'b10), 1, 24, 6);
        add(7'd99, 3'b000, 0, 1, 1, 1, st_decode(2'b10));
        add(7'd99, 3'b000, 0, 1, 1, 1, st_beq(1'b1));
        add(7'd99, 3'b000, 0, 0, 1, 1, st_fetch(1, 2'b10), 1, 27, 7);
        add(7'd99, 3'b000, 0, 0, 1, 1, st_decode(2'b10));
        add(7'd99, 3'b000, 0, 0, 1, 1, st_beq(1'b0));
        // jal
        add(7'd111, 3'b000, 0, 0, 1, 1, st_fetch(1, 2'b11), 1, 30, 8);
        add(7'd111, 3'b000, 0, 0, 1, 1, st_decode(2'b11));
        add(7'd111, 3'b000, 0, 0, 1, 1, st_jal());
        add(7'd111, 3'b000, 0, 0, 1, 1, st_aluwb(2'b11));
        // lw with 3 fetch and 2 read wait states (handshake instance only)
        add(7'd3, 3'b010, 0, 0, 0, 0, st_fetch(0, 2'b00), 1, 34, 9);
        add(7'd3, 3'b010, 0, 0, 0, 0, st_fetch(0, 2'b00));
        add(7'd3, 3'b010, 0, 0, 0, 0, st_fetch(0, 2'b00));
        add(7'd3, 3'b010, 0, 0, 1, 0, st_fetch(1, 2'b00));
        add(7'd3, 3'b010, 0, 0, 1, 0, st_decode(2'b00));
        add(7'd3, 3'b010, 0, 0, 1, 0, st_memadr(2'b00));
        add(7'd3, 3'b010, 0, 0, 0, 0, st_memread());
        add(7'd3, 3'b010, 0, 0, 0, 0, st_memread());
        add(7'd3, 3'b010, 0, 0, 1, 0, st_memread());
        add(7'd3, 3'b010, 0, 0, 1, 0, st_memwb());
        // sw with one write wait state
        add(7'd35, 3'b010, 0, 0, 1, 0, st_fetch(1, 2'b01), 1, 44, 10);
        add(7'd35, 3'b010, 0, 0, 1, 0, st_decode(2'b01));
        add(7'd35, 3'b010, 0, 0, 1, 0, st_memadr(2'b01));
        add(7'd35, 3'b010, 0, 0, 0, 0, st_memwrite(1'b0));
        add(7'd35, 3'b010, 0, 0, 1, 0, st_memwrite(1'b1));
        // illegal opcode: TRAP with counters frozen
        add(7'h7F, 3'b000, 0, 1, 1, 0, st_fetch(1, 2'b00), 1, 49, 11);
        add(7'h7F, 3'b000, 0, 1, 1, 0, st_decode(2'b00));
        add(7'h7F, 3'b000, 0, 1, 1, 0, st_trap(), 1, 51, 11);
        add(7'h7F, 3'b000, 0, 1, 1, 0, st_trap());
        add(7'h7F, 3'b000, 0, 1, 1, 0, st_trap(), 1, 51, 11);
        // illegal funct3 on R-type
        add_rst();
        add(7'd51, 3'b001, 0, 0, 1, 1, st_fetch(1, 2'b00), 1, 0, 0);
        add(7'd51, 3'b001, 0, 0, 1, 1, st_decode(2'b00));
        add(7'd51, 3'b001, 0, 0, 1, 1, st_trap(), 1, 2, 0);
        // reset in the middle of a lw abandons it
        add_rst();
        add(7'd3, 3'b010, 0, 0, 1, 1, st_fetch(1, 2'b00));
        add(7'd3, 3'b010, 0, 0, 1, 1, st_decode(2'b00));
        add(7'd3, 3'b010, 0, 0, 1, 1, st_memadr(2'b00));
        add_rst();
        add_alu(7'd19, 3'b000, 1'b0, 3'b000, 0, 0);
        add(7'd111, 3'b000, 0, 0, 1, 1, st_fetch(1, 2'b11), 1, 4, 1);

        foreach (vecs[i]) begin
            if (vecs[i].is_rst) begin
                do_reset(i);
            end else begin
                op          = vecs[i].op;
                funct3      = vecs[i].f3;
                funct7_bit5 = vecs[i].f7;
                zero        = vecs[i].z;
                mem_ready_b = vecs[i].rdy;
                mem_ready_a = 1'b0;
                sb_q.push_back(vecs[i].exp);
                @(negedge clk);
                e = sb_q.pop_front();
                check_outs("outs_b", i, got_b, e);
                if (vecs[i].both) begin
                    check_outs("outs_a", i, got_a, e);
                end
                if (vecs[i].cc) begin
                    check_val("cycle_cnt", i, cyc_b, 32'(vecs[i].cyc));
                    check_val("instret_cnt", i, ins_b, 32'(vecs[i].ins));
                end
                $display("vec %0d op=%0d f3=%0d rdy=%0b outs_b=%b cyc=%0d ins=%0d",
                         i, op, funct3, mem_ready_b, got_b, cyc_b, ins_b);
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
